cpu_cmd_mailbox: RTL and testbench
==================================

// Module: cpu_cmd_mailbox
// PURPOSE
//  Parametrised CPU<->N64 command mailbox on the CPU bus (cpu_cfg successor).
//  N64 side pushes 8-bit commands into a CMD_DEPTH FIFO and shares DATA_WORDS 32-bit
//  argument words. The CPU pops commands, sets busy, then posts completion/error.
//  Provides a CPU interrupt on pending commands and a sticky overflow flag.
// PARAMETERS
//  DATA_WORDS  4  shared 32-bit argument words, 1..8
//  CMD_DEPTH   4  command FIFO depth, power of 2, 2..16
// PORTS
//  sys.clk          in   1   system clock (if_system.sys)
//  sys.reset        in   1   synchronous, active-high reset
//  sys.n64_soft_reset in 1   N64 soft reset pulse
//  bus.request      in   1   CPU bus access strobe (if_cpu_bus)
//  bus.address      in   32  byte address; [5:2] selects register
//  bus.wmask        in   4   byte write mask; 0 = read
//  bus.wdata        in   32  write data
//  bus.ack          out  1   access ack, 1 cycle after request
//  bus.rdata        out  32  read data, valid only while ack
//  host_cmd_valid   in   1   N64 command push request
//  host_cmd         in   8   N64 command code
//  host_cmd_ready   out  1   FIFO not full (count < CMD_DEPTH)
//  host_wdata       in   32  N64 data word write value
//  host_data_write  in   DATA_WORDS  per-word N64 write strobes
//  host_data        out  32*DATA_WORDS  shared data words, word i at [32i+:32]
//  host_done        out  1   1-cycle pulse on CPU completion
//  host_error       out  1   error status of last completion
//  host_busy        out  1   CPU processing a command
//  cpu_irq          out  1   irq_enable & FIFO non-empty
// BEHAVIOUR
//  Reset: FIFO empty, count 0, busy/error/overflow/irq_enable 0, data words 0,
//   ack 0, rdata 0, host_done 0, host_cmd_ready 1.
//  Bus: ack <= request; rdata captured in request cycle, driven during ack, else 0.
//  Register map (address[5:2]):
//   0 SCR  R: [31]busy [30]error [29]overflow [28]irq_enable [12:8]count [0]empty
//          W: wmask[3]: irq_enable<=wdata[28]; wdata[29]=1 clears overflow (W1C)
//   1 CMD  R: {valid,23'd0,head}; non-empty: pop head, busy<=1; empty: 0, no pop
//   2 DONE W: busy<=0, error<=wdata[0], host_done pulses next cycle; R: 0
//   4..4+DATA_WORDS-1 DATA: R/W, full-word writes only (&wmask), else ignored
//   other addresses: read 0, writes ignored
//  FIFO: push when host_cmd_valid & host_cmd_ready; push while full dropped and
//   sets overflow. Push+pop same cycle: both happen, count unchanged. Pointers
//   wrap modulo CMD_DEPTH; count is $clog2(CMD_DEPTH)+1 bits.
//  Data: CPU and host write same word same cycle -> CPU value wins.
//  DONE while not busy: error updated, host_done still pulses.
//  CMD pop and DONE never same cycle (one bus access per request).
//  n64_soft_reset: FIFO flushed, busy<=0, overflow<=0; data, error, irq_enable
//   kept. Soft reset and push same cycle: flush wins, push dropped.
//  sys.reset mid-access: ack and rdata forced 0 next cycle, no pop.
//  cpu_irq combinational from registered irq_enable and count.
// TESTING
//  1. Push 0x11,0x22; read SCR -> count=2, empty=0; read CMD twice -> 0x80000011, 0x80000022, busy=1.
//  2. Fill 4 cmds, push 5th -> host_cmd_ready=0, overflow=1, count=4; write SCR[29]=1 -> overflow=0.
//  3. irq_enable=1, empty -> cpu_irq=0; push 0x05 -> cpu_irq=1 next cycle; pop -> 0.
//  4. Pop, write DONE wdata=1 -> busy=0, host_error=1, host_done 1-cycle pulse.
//  5. CPU writes DATA1=0xDEADBEEF while host writes 0x12345678 same cycle -> host_data[63:32]=0xDEADBEEF; wmask=4'b0011 -> no change.
//  6. 3 cmds queued, busy=1, n64_soft_reset -> count=0, busy=0, CMD read returns 0.

Source files
------------

// File: rtl/cpu_cmd_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_cmd_mailbox
//  Description : CPU <-> N64 command mailbox on the CPU bus. The N64 side
//                pushes 8-bit commands into a small FIFO and shares a set of
//                32-bit argument words; the CPU pops commands, marks itself
//                busy and posts completion/error status back to the host.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_cmd_mailbox #(
  parameter int DATA_WORDS = 4,   // shared argument words, 1..8
  parameter int CMD_DEPTH  = 4    // command FIFO depth, power of 2, 2..16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       n64_soft_reset,
  // CPU bus
  input  logic                       request,
  input  logic [31:0]                address,
  input  logic [3:0]                 wmask,
  input  logic [31:0]                wdata,
  output logic                       ack,
  output logic [31:0]                rdata,
  // N64 host side
  input  logic                       host_cmd_valid,
  input  logic [7:0]                 host_cmd,
  output logic                       host_cmd_ready,
  input  logic [31:0]                host_wdata,
  input  logic [DATA_WORDS-1:0]      host_data_write,
  output logic [32*DATA_WORDS-1:0]   host_data,
  output logic                       host_done,
  output logic                       host_error,
  output logic                       host_busy,
  output logic                       cpu_irq
);

  localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [3:0] REG_SCR  = 4'd0;
  localparam logic [3:0] REG_CMD  = 4'd1;
  localparam logic [3:0] REG_DONE = 4'd2;

  logic [7:0]    fifo_mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          busy;
  logic          error;
  logic          overflow;
  logic          irq_enable;
  logic          done_pulse;
  logic [31:0]   data_q [DATA_WORDS];

  logic [3:0]    sel;
  logic          rd_access;
  logic          wr_access;
  logic          fifo_empty;
  logic          push;
  logic          drop;
  logic          pop;
  logic          scr_wr;
  logic          done_wr;
  logic [4:0]    count_ext;
  logic [31:0]   rd_value;
  logic          unused_addr_bits;

  assign sel        = address[5:2];
  assign rd_access  = request & (wmask == 4'd0);
  assign wr_access  = request & (|wmask);
  assign fifo_empty = (count == '0);

  assign host_cmd_ready = (count < CW'(CMD_DEPTH));

  // Soft reset flushes the FIFO, so a push or pop in the same cycle is void.
  assign push    = host_cmd_valid &  host_cmd_ready & ~n64_soft_reset;
  assign drop    = host_cmd_valid & ~host_cmd_ready & ~n64_soft_reset;
  assign pop     = rd_access & (sel == REG_CMD) & ~fifo_empty & ~n64_soft_reset;
  assign scr_wr  = wr_access & (sel == REG_SCR) & wmask[3];
  assign done_wr = wr_access & (sel == REG_DONE);

  assign count_ext = 5'(count);

  assign host_done  = done_pulse;
  assign host_error = error;
  assign host_busy  = busy;
  assign cpu_irq    = irq_enable & ~fifo_empty;

  assign unused_addr_bits = ^{address[31:6], address[1:0]};

  // Read data mux for the register addressed in the current request.
  always_comb begin
    rd_value = '0;
    case (sel)
      REG_SCR: rd_value = {busy, error, overflow, irq_enable, 15'd0,
                           count_ext, 7'd0, fifo_empty};
      REG_CMD: if (!fifo_empty) rd_value = {1'b1, 23'd0, fifo_mem[rd_ptr]};
      default: begin
        for (int i = 0; i < DATA_WORDS; i++) begin
          if (sel == 4'(4 + i)) rd_value = data_q[i];
        end
      end
    endcase
  end

  // Bus response: ack one cycle after request, rdata only alongside ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= request;
      rdata <= rd_access ? rd_value : 32'd0;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at CMD_DEPTH.
  always_ff @(posedge clk) begin
    if (reset || n64_soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= host_cmd;
  end

  // Status/control: busy, error, overflow, irq enable and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      error      <= 1'b0;
      overflow   <= 1'b0;
      irq_enable <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= done_wr;
      if (pop) busy <= 1'b1;
      if (done_wr) begin
        busy  <= 1'b0;
        error <= wdata[0];
      end
      if (scr_wr) begin
        irq_enable <= wdata[28];
        if (wdata[29]) overflow <= 1'b0;
      end
      // A fresh drop takes priority over a simultaneous clear.
      if (drop) overflow <= 1'b1;
      if (n64_soft_reset) begin
        busy     <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DATA_WORDS; gi++) begin : g_data_word
      logic cpu_wr;
      assign cpu_wr = wr_access & (&wmask) & (sel == 4'(4 + gi));

      // Shared argument word; a CPU write beats a same-cycle host write.
      always_ff @(posedge clk) begin
        if (reset) begin
          data_q[gi] <= '0;
        end else if (cpu_wr) begin
          data_q[gi] <= wdata;
        end else if (host_data_write[gi]) begin
          data_q[gi] <= host_wdata;
        end
      end

      assign host_data[32*gi +: 32] = data_q[gi];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cpu_cmd_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_cmd_mailbox
//  Description : Self-checking bench for cpu_cmd_mailbox. Bus reads queue
//                their expected rdata; a monitor pops and compares on ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_cmd_mailbox;

  localparam int DW = 4;
  localparam int CD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          n64_soft_reset;
  logic          request;
  logic [31:0]   address;
  logic [3:0]    wmask;
  logic [31:0]   wdata;
  logic          ack;
  logic [31:0]   rdata;
  logic          host_cmd_valid;
  logic [7:0]    host_cmd;
  logic          host_cmd_ready;
  logic [31:0]   host_wdata;
  logic [DW-1:0] host_data_write;
  logic [32*DW-1:0] host_data;
  logic          host_done;
  logic          host_error;
  logic          host_busy;
  logic          cpu_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  cpu_cmd_mailbox #(.DATA_WORDS(DW), .CMD_DEPTH(CD)) dut (
    .clk(clk), .reset(reset), .n64_soft_reset(n64_soft_reset),
    .request(request), .address(address), .wmask(wmask), .wdata(wdata),
    .ack(ack), .rdata(rdata),
    .host_cmd_valid(host_cmd_valid), .host_cmd(host_cmd),
    .host_cmd_ready(host_cmd_ready), .host_wdata(host_wdata),
    .host_data_write(host_data_write), .host_data(host_data),
    .host_done(host_done), .host_error(host_error), .host_busy(host_busy),
    .cpu_irq(cpu_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic bus_read(input string nm, input logic [3:0] reg_idx, input logic [31:0] exp);
    exp_t e;
    e.name = nm;
    e.val  = exp;
    sb_q.push_back(e);
    request = 1'b1;
    address = {26'd0, reg_idx, 2'b00};
    wmask   = 4'd0;
    tick();
    request = 1'b0;
    address = '0;
  endtask

  task automatic bus_write(input logic [3:0] reg_idx, input logic [3:0] m, input logic [31:0] d);
    exp_t e;
    e.name = "write_ack";
    e.val  = 32'd0;
    sb_q.push_back(e);
    request = 1'b1;
    address = {26'd0, reg_idx, 2'b00};
    wmask   = m;
    wdata   = d;
    tick();
    request = 1'b0;
    address = '0;
    wmask   = '0;
    wdata   = '0;
  endtask

  task automatic push_cmd(input logic [7:0] c);
    host_cmd_valid = 1'b1;
    host_cmd       = c;
    tick();
    host_cmd_valid = 1'b0;
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (ack) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack rdata=%h expected no access", rdata);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (rdata !== e.val) begin
            errors++;
            $display("FAIL %s rdata=%h expected=%h", e.name, rdata, e.val);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; n64_soft_reset = 1'b0;
    request = 1'b0; address = '0; wmask = '0; wdata = '0;
    host_cmd_valid = 1'b0; host_cmd = '0; host_wdata = '0; host_data_write = '0;
    repeat (3) tick();

    // Reset state
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", 32'(host_cmd_ready), 32'd1);
    check("rst_done", 32'(host_done), 32'd0);
    check("rst_busy", 32'(host_busy), 32'd0);
    check("rst_irq", 32'(cpu_irq), 32'd0);
    check("rst_data_lo", host_data[31:0], 32'd0);
    reset = 1'b0;
    tick();
    bus_read("rst_scr", 4'd0, 32'h0000_0001);

    // Two commands, pop both
    push_cmd(8'h11);
    push_cmd(8'h22);
    bus_read("t1_scr", 4'd0, 32'h0000_0200);
    bus_read("t1_cmd0", 4'd1, 32'h8000_0011);
    bus_read("t1_cmd1", 4'd1, 32'h8000_0022);
    check("t1_busy", 32'(host_busy), 32'd1);
    bus_read("t1_scr_busy", 4'd0, 32'h8000_0001);

    // Completion with error, then completion while idle
    bus_write(4'd2, 4'hF, 32'd1);
    check("t4_done_pulse", 32'(host_done), 32'd1);
    check("t4_busy", 32'(host_busy), 32'd0);
    check("t4_error", 32'(host_error), 32'd1);
    tick();
    check("t4_done_end", 32'(host_done), 32'd0);
    bus_read("t4_scr", 4'd0, 32'h4000_0001);
    bus_read("t4_done_rd", 4'd2, 32'd0);
    bus_write(4'd2, 4'hF, 32'd0);
    check("t4_idle_done", 32'(host_done), 32'd1);
    check("t4_idle_error", 32'(host_error), 32'd0);

    // Fill, overflow, W1C clear, drain
    for (int i = 0; i < CD; i++) push_cmd(8'hA0 + 8'(i));
    check("t2_ready_full", 32'(host_cmd_ready), 32'd0);
    push_cmd(8'hA4);
    bus_read("t2_scr_ovf", 4'd0, 32'h2000_0400);
    bus_write(4'd0, 4'b1000, 32'h2000_0000);
    bus_read("t2_scr_clr", 4'd0, 32'h0000_0400);
    for (int i = 0; i < CD; i++) bus_read("t2_drain", 4'd1, 32'h8000_00A0 + 32'(i));
    bus_read("t2_cmd_empty", 4'd1, 32'd0);
    bus_write(4'd2, 4'hF, 32'd0);

    // Interrupt
    bus_write(4'd0, 4'b1000, 32'h1000_0000);
    check("t3_irq_empty", 32'(cpu_irq), 32'd0);
    push_cmd(8'h05);
    check("t3_irq_pending", 32'(cpu_irq), 32'd1);
    bus_read("t3_cmd", 4'd1, 32'h8000_0005);
    check("t3_irq_popped", 32'(cpu_irq), 32'd0);
    bus_read("t3_scr", 4'd0, 32'h9000_0001);

    // Shared data words
    host_data_write = 4'b0010;
    host_wdata      = 32'h1234_5678;
    bus_write(4'd5, 4'hF, 32'hDEAD_BEEF);
    host_data_write = '0;
    check("t5_cpu_wins", host_data[63:32], 32'hDEAD_BEEF);
    host_data_write = 4'b0100;
    host_wdata      = 32'hCAFE_F00D;
    tick();
    host_data_write = '0;
    check("t5_host_wr", host_data[95:64], 32'hCAFE_F00D);
    bus_write(4'd5, 4'b0011, 32'h0000_0000);
    check("t5_partial", host_data[63:32], 32'hDEAD_BEEF);
    bus_read("t5_rd_data1", 4'd5, 32'hDEAD_BEEF);
    bus_read("t5_rd_data2", 4'd6, 32'hCAFE_F00D);
    bus_read("t5_rd_unmapped", 4'd3, 32'd0);
    bus_read("t5_rd_beyond", 4'd8, 32'd0);

    // Soft reset flush
    push_cmd(8'hC1);
    push_cmd(8'hC2);
    push_cmd(8'hC3);
    bus_read("t6_scr_pre", 4'd0, 32'h9000_0300);
    n64_soft_reset = 1'b1;
    tick();
    n64_soft_reset = 1'b0;
    check("t6_busy", 32'(host_busy), 32'd0);
    check("t6_ready", 32'(host_cmd_ready), 32'd1);
    bus_read("t6_scr_post", 4'd0, 32'h1000_0001);
    bus_read("t6_cmd", 4'd1, 32'd0);
    check("t6_data_kept", host_data[63:32], 32'hDEAD_BEEF);
    host_cmd_valid = 1'b1;
    host_cmd       = 8'h77;
    n64_soft_reset = 1'b1;
    tick();
    host_cmd_valid = 1'b0;
    n64_soft_reset = 1'b0;
    bus_read("t6_push_flush", 4'd0, 32'h1000_0001);

    // Reset in the middle of an access
    push_cmd(8'h33);
    request = 1'b1;
    address = 32'h0000_0004;
    wmask   = 4'd0;
    reset   = 1'b1;
    tick();
    request = 1'b0;
    address = '0;
    reset   = 1'b0;
    check("rst_mid_ack", 32'(ack), 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    tick();
    bus_read("rst_mid_scr", 4'd0, 32'h0000_0001);

    repeat (3) tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
